// File: rtl/register_file_sb.sv
// register_file_sb: parametrised integer register file with scoreboard.
// Entry 0 reads as zero and is not stored. A post-reset clear engine zeroes
// entries 1..NREG-1 one per edge before ready_o asserts. Each entry carries
// a pending bit that is set on issue and cleared on writeback.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   ready_o                 clear complete, file accepting operations
//   ra1_i/ra2_i             read addresses
//   rd1_o/rd2_o             read data (combinational)
//   busy1_o/busy2_o         pending bit of the read address (combinational)
//   we3_i/wa3_i/wd3_i       writeback enable / address / data
//   iss_en_i/iss_rd_i       issue enable / destination register
module register_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready_o,
    input  logic [$clog2(NREG)-1:0]  ra1_i,
    input  logic [$clog2(NREG)-1:0]  ra2_i,
    output logic [XLEN-1:0]          rd1_o,
    output logic [XLEN-1:0]          rd2_o,
    output logic                     busy1_o,
    output logic                     busy2_o,
    input  logic                     we3_i,
    input  logic [$clog2(NREG)-1:0]  wa3_i,
    input  logic [XLEN-1:0]          wd3_i,
    input  logic                     iss_en_i,
    input  logic [$clog2(NREG)-1:0]  iss_rd_i
);

    localparam int unsigned AW  = $clog2(NREG);
    localparam bit          BYP = (BYPASS != 0);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic [NREG-1:1]   pending_q, pending_d;
    logic [XLEN-1:0]   rf_q [1:NREG-1];

    // Clear engine: walks clr_cnt from 1 up to NREG-1, then enters RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == AW'(NREG - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Scoreboard update: writeback clears, issue sets afterwards so it wins.
    always_comb begin
        pending_d = pending_q;
        if (ready_q) begin
            for (int i = 1; i < NREG; i++) begin
                if (we3_i && (wa3_i == AW'(i))) begin
                    pending_d[i] = 1'b0;
                end
                if (iss_en_i && (iss_rd_i == AW'(i))) begin
                    pending_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= AW'(1);
            ready_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
        end
    end

    // Array: zeroed by the clear engine, written by writeback once ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < NREG; i++) begin
                if (state_q == CLEAR) begin
                    if (clr_cnt_q == AW'(i)) begin
                        rf_q[i] <= '0;
                    end
                end else if (ready_q && we3_i && (wa3_i == AW'(i))) begin
                    rf_q[i] <= wd3_i;
                end
            end
        end
    end

    // Read ports: array lookup, then optional same-cycle forwarding.
    logic [XLEN-1:0] arr1, arr2;
    logic            pend1, pend2, hit1, hit2, iss1, iss2;

    always_comb begin
        arr1  = '0;
        arr2  = '0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (ra1_i == AW'(i)) begin
                arr1  = rf_q[i];
                pend1 = pending_q[i];
            end
            if (ra2_i == AW'(i)) begin
                arr2  = rf_q[i];
                pend2 = pending_q[i];
            end
        end
        hit1 = BYP && we3_i && (wa3_i == ra1_i);
        hit2 = BYP && we3_i && (wa3_i == ra2_i);
        iss1 = BYP && iss_en_i && (iss_rd_i == ra1_i);
        iss2 = BYP && iss_en_i && (iss_rd_i == ra2_i);

        rd1_o   = '0;
        busy1_o = 1'b0;
        if (ready_q && (ra1_i != '0)) begin
            rd1_o   = hit1 ? wd3_i : arr1;
            busy1_o = (pend1 & ~hit1) | iss1;
        end
        rd2_o   = '0;
        busy2_o = 1'b0;
        if (ready_q && (ra2_i != '0)) begin
            rd2_o   = hit2 ? wd3_i : arr2;
            busy2_o = (pend2 & ~hit2) | iss2;
        end
    end

    assign ready_o = ready_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb: one instance with forwarding, one without,
// sharing stimulus and compared against a behavioural model of the file.
module tb_register_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    bit              clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   ra1, ra2, wa3, iss_rd;
    logic [XLEN-1:0] wd3;
    logic            we3, iss_en;

    logic            rdy_b, rdy_n, b1_b, b2_b, b1_n, b2_n;
    logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;

    always #5 clk = ~clk;

    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .ready_o(rdy_b),
        .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1_b), .rd2_o(rd2_b),
        .busy1_o(b1_b), .busy2_o(b2_b),
        .we3_i(we3), .wa3_i(wa3), .wd3_i(wd3),
        .iss_en_i(iss_en), .iss_rd_i(iss_rd)
    );

    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .ready_o(rdy_n),
        .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1_n), .rd2_o(rd2_n),
        .busy1_o(b1_n), .busy2_o(b2_n),
        .we3_i(we3), .wa3_i(wa3), .wd3_i(wd3),
        .iss_en_i(iss_en), .iss_rd_i(iss_rd)
    );

    // Reference model: architectural contents, pending set, clear progress.
    logic [XLEN-1:0] m_rf [NREG];
    bit              m_pend [NREG];
    bit              m_ready;
    int              m_clr_edges;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra, input bit byp);
        if (ra == 0 || !m_ready) return '0;
        if (byp && we3 && wa3 == ra) return wd3;
        return m_rf[ra];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] ra, input bit byp);
        if (ra == 0 || !m_ready) return 1'b0;
        if (!byp) return m_pend[ra];
        return (m_pend[ra] && !(we3 && wa3 == ra)) || (iss_en && iss_rd == ra);
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_ready     = 1'b0;
            m_clr_edges = 0;
            for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_clr_edges++;
            m_rf[m_clr_edges] = '0;
            if (m_clr_edges == NREG - 1) m_ready = 1'b1;
        end else begin
            if (we3 && wa3 != 0) begin
                m_rf[wa3]   = wd3;
                m_pend[wa3] = 1'b0;
            end
            if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1'b1;
        end
    endtask

    // Called just after a falling edge with inputs driven: check, then clock.
    task automatic step();
        #1;
        check("ready_byp", 64'(rdy_b), 64'(m_ready));
        check("ready_nob", 64'(rdy_n), 64'(m_ready));
        check("rd1_byp",   64'(rd1_b), 64'(exp_rd(ra1, 1'b1)));
        check("rd2_byp",   64'(rd2_b), 64'(exp_rd(ra2, 1'b1)));
        check("busy1_byp", 64'(b1_b),  64'(exp_busy(ra1, 1'b1)));
        check("busy2_byp", 64'(b2_b),  64'(exp_busy(ra2, 1'b1)));
        check("rd1_nob",   64'(rd1_n), 64'(exp_rd(ra1, 1'b0)));
        check("rd2_nob",   64'(rd2_n), 64'(exp_rd(ra2, 1'b0)));
        check("busy1_nob", 64'(b1_n),  64'(exp_busy(ra1, 1'b0)));
        check("busy2_nob", 64'(b2_n),  64'(exp_busy(ra2, 1'b0)));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b0; we3 = 1'b0; iss_en = 1'b0;
        wa3 = '0; wd3 = '0; iss_rd = '0; ra1 = '0; ra2 = '0;
    endtask

    // Counts low-ready cycles after reset release; bounded.
    task automatic clear_and_count(input string tag);
        int n;
        n = 0;
        reset = 1'b0;
        for (int k = 0; k < 40 && rdy_b !== 1'b1; k++) begin
            n++;
            step();
        end
        check(tag, 64'(n), 64'(NREG - 1));
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_rf[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_ready = 1'b0;
        m_clr_edges = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_edge();
        @(negedge clk);
        step();
        clear_and_count("clr_len_first");

        // Preload r5, then reset; a write to r7 during clear must be dropped.
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF; step();
        idle(); ra1 = 5'd5; step();
        reset = 1'b1; step();
        reset = 1'b0;
        for (int k = 0; k < NREG - 1; k++) begin
            we3 = (k == 3); wa3 = 5'd7; wd3 = 32'h0BAD_F00D;
            step();
        end
        idle(); ra1 = 5'd5; ra2 = 5'd31;
        #1 check("r5_cleared", 64'(rd1_b), 64'h0);
        step();
        ra1 = 5'd7;
        #1 check("r7_dropped", 64'(rd1_b), 64'h0);
        step();

        // Write r3 and r0, read back.
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h12345678; step();
        wa3 = 5'd0; wd3 = 32'hFFFFFFFF; step();
        idle(); ra1 = 5'd3; ra2 = 5'd0;
        #1 check("r3_read", 64'(rd1_b), 64'h12345678);
        check("r0_read", 64'(rd2_n), 64'h0);
        step();

        // Forwarding: same-cycle write to r9.
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hA5A5A5A5; ra1 = 5'd9;
        #1 check("byp_fwd", 64'(rd1_b), 64'hA5A5A5A5);
        step();
        idle(); ra1 = 5'd9;
        #1 check("nob_next", 64'(rd1_n), 64'hA5A5A5A5);
        step();

        // Scoreboard: issue r4, writeback clears.
        iss_en = 1'b1; iss_rd = 5'd4; ra1 = 5'd4; step();
        idle(); ra1 = 5'd4;
        #1 check("busy_after_iss", 64'(b1_n), 64'h1);
        step();
        we3 = 1'b1; wa3 = 5'd4; wd3 = 32'h11; ra1 = 5'd4;
        #1 check("busy_drop_wb", 64'(b1_b), 64'h0);
        step();
        idle(); ra1 = 5'd4; step();

        // Issue/writeback collision on r6; then x0 no-ops.
        iss_en = 1'b1; iss_rd = 5'd6; we3 = 1'b1; wa3 = 5'd6; wd3 = 32'h22; step();
        idle(); ra1 = 5'd6;
        #1 check("coll_rd", 64'(rd1_n), 64'h22);
        check("coll_busy", 64'(b1_n), 64'h1);
        step();
        iss_en = 1'b1; iss_rd = 5'd0; we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h33; step();
        idle(); ra1 = 5'd0; ra2 = 5'd6; step();

        // Mark several pending, then reset mid-clear.
        for (int r = 1; r < NREG; r += 3) begin
            idle(); iss_en = 1'b1; iss_rd = AW'(r); step();
        end
        idle(); reset = 1'b1; step();
        reset = 1'b0;
        repeat (9) step();
        reset = 1'b1; step();
        clear_and_count("clr_len_restart");
        for (int r = 0; r < NREG; r += 2) begin
            idle(); ra1 = AW'(r); ra2 = AW'(r + 1); step();
        end

        // Randomised traffic with collisions biased in.
        for (int c = 0; c < 1500; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            we3    = $urandom_range(0, 1) == 1;
            wa3    = AW'($urandom_range(0, NREG - 1));
            wd3    = $urandom;
            iss_en = $urandom_range(0, 2) == 0;
            iss_rd = ($urandom_range(0, 3) == 0) ? wa3 : AW'($urandom_range(0, NREG - 1));
            ra1    = ($urandom_range(0, 2) == 0) ? wa3 : AW'($urandom_range(0, NREG - 1));
            ra2    = ($urandom_range(0, 2) == 0) ? iss_rd : AW'($urandom_range(0, NREG - 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
